// File: rtl/speed_test_pkg.sv
// rtl/speed_test_pkg.sv - shared types, phase lengths and width helper for the ring speed monitor
`timescale 1ns/1ps
package speed_test_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_COUNT  = 3'd2,
      ST_SETTLE = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam int SYNC_STAGES   = 2;
   localparam int CLEAR_CYCLES  = 2;
   localparam int SETTLE_CYCLES = 3;

   // select width for n items, never narrower than one bit
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ring_counter.sv
// rtl/ring_counter.sv - one channel: ring, win/clr synchronisers, down-counter; RING_OVF_EN adds sticky ovf
`timescale 1ns/1ps
module ring_counter
   import speed_test_pkg::*;
#(
   parameter int RING_STAGES = 25,
   parameter int CNT_W       = 24
) (
   input  logic             ring_en,
   input  logic             win,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             ovf
);

   logic                   ring_clk;
   logic [SYNC_STAGES-1:0] win_sync;
   logic [SYNC_STAGES-1:0] clr_sync;

   // clr keeps a disabled ring alive so its counter still gets loaded with all-ones
   ring_osc #(.RING_STAGES(RING_STAGES)) u_osc (
      .en       (ring_en | clr),
      .ring_out (ring_clk)
   );

   // bring the clk-domain window and clear into the ring domain
   always_ff @(posedge ring_clk) begin
      win_sync <= {win_sync[SYNC_STAGES-2:0], win};
      clr_sync <= {clr_sync[SYNC_STAGES-2:0], clr};
   end

`ifdef RING_OVF_EN
   logic ovf_sticky;

   // count down during the window; stop at zero and remember that it happened
   always_ff @(posedge ring_clk) begin
      if (clr_sync[SYNC_STAGES-1]) begin
         count      <= '1;
         ovf_sticky <= 1'b0;
      end else if (win_sync[SYNC_STAGES-1]) begin
         if (count == '0) ovf_sticky <= 1'b1;
         else             count      <= count - 1'b1;
      end
   end
   assign ovf = ovf_sticky;
`else
   // count down during the window, wrapping modulo 2^CNT_W
   always_ff @(posedge ring_clk) begin
      if (clr_sync[SYNC_STAGES-1])      count <= '1;
      else if (win_sync[SYNC_STAGES-1]) count <= count - 1'b1;
   end
   assign ovf = 1'b0;
`endif

endmodule

// File: rtl/ring_osc.sv
// rtl/ring_osc.sv - gated ring oscillator; inverter chain for SYNTHESIS, timed toggle model otherwise
`timescale 1ns/1ps
module ring_osc
   import speed_test_pkg::*;
#(
   parameter int RING_STAGES = 25
) (
   input  logic en,
   output logic ring_out
);

`ifdef SYNTHESIS
   logic [RING_STAGES-1:0] node;

   // one NAND as the enable gate plus RING_STAGES-1 inverters keeps the loop odd
   assign node[0] = ~(node[RING_STAGES-1] & en);
   for (genvar i = 1; i < RING_STAGES; i++) begin : g_inv
      assign node[i] = ~node[i-1];
   end
   assign ring_out = node[RING_STAGES-1];
`else
   // 80 ps per stage, so the default 25-stage ring has a 2 ns half-period; settable from a bench
   realtime half_period = RING_STAGES * 0.08;
   logic    osc = 1'b0;

   // free-running toggle; a disabled ring parks low and produces no edges
   always begin
      #(half_period);
      osc <= en ? ~osc : 1'b0;
   end
   assign ring_out = osc;
`endif

endmodule

// File: rtl/multi_ring_speed_test.sv
// rtl/multi_ring_speed_test.sv - N-channel ring speed monitor: trigger FSM, window timer, byte readout
`timescale 1ns/1ps
module multi_ring_speed_test
   import speed_test_pkg::*;
#(
   parameter int NUM_RINGS   = 2,
   parameter int RING_STAGES = 25,
   parameter int CNT_W       = 24,
   parameter int WIN_W       = 4
) (
   input  logic                                clk,
   input  logic                                nrst,
   input  logic                                trig,
   input  logic [NUM_RINGS-1:0]                ring_en,
   input  logic [WIN_W-1:0]                    win_cycles,
   input  logic [clog2_min1(NUM_RINGS)-1:0]    rd_ch,
   input  logic [clog2_min1(CNT_W/8)-1:0]      rd_byte,
   output logic [7:0]                          rd_data,
   output logic                                busy,
   output logic                                fired,
   output logic [NUM_RINGS-1:0]                ovf
);

   localparam int NUM_BYTES = CNT_W / 8;

   state_t               state;
   state_t               state_next;
   logic                 trig_q;
   logic                 trig_rise;
   logic [WIN_W-1:0]     phase_cnt;
   logic [WIN_W-1:0]     win_len;
   logic                 win;
   logic                 clr;
   logic [CNT_W-1:0]     counts [NUM_RINGS];
   logic [NUM_RINGS-1:0] ovf_ring;
   logic [NUM_RINGS-1:0] ovf_meta;
   logic [7:0]           rd_next;

   assign trig_rise = trig & ~trig_q;

   // state register, per-phase cycle counter, window latch and trig history
   always_ff @(posedge clk) begin
      trig_q <= trig;
      if (!nrst) begin
         state     <= ST_IDLE;
         phase_cnt <= '0;
         win_len   <= '0;
      end else begin
         state     <= state_next;
         phase_cnt <= (state_next != state) ? '0 : phase_cnt + 1'b1;
         if (state_next == ST_CLEAR && state != ST_CLEAR)
            win_len <= (win_cycles == '0) ? WIN_W'(1) : win_cycles;
      end
   end

   // sequencing; trig edges outside IDLE/DONE fall on the floor
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE, ST_DONE: if (trig_rise) state_next = ST_CLEAR;
         ST_CLEAR:  if (phase_cnt == WIN_W'(CLEAR_CYCLES - 1))  state_next = ST_COUNT;
         ST_COUNT:  if (phase_cnt == win_len - 1'b1)            state_next = ST_SETTLE;
         ST_SETTLE: if (phase_cnt == WIN_W'(SETTLE_CYCLES - 1)) state_next = ST_DONE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // decode the phase controls; IDLE holds clr so counters sit at all-ones after reset
   always_comb begin
      busy  = 1'b0;
      fired = 1'b0;
      win   = 1'b0;
      clr   = 1'b0;
      case (state)
         ST_IDLE:   clr = 1'b1;
         ST_CLEAR:  begin clr = 1'b1; busy = 1'b1; end
         ST_COUNT:  begin win = 1'b1; busy = 1'b1; end
         ST_SETTLE: busy = 1'b1;
         ST_DONE:   fired = 1'b1;
         default:   clr = 1'b1;
      endcase
   end

   for (genvar ch = 0; ch < NUM_RINGS; ch++) begin : g_ch
      ring_counter #(.RING_STAGES(RING_STAGES), .CNT_W(CNT_W)) u_rc (
         .ring_en (ring_en[ch]),
         .win     (win),
         .clr     (clr),
         .count   (counts[ch]),
         .ovf     (ovf_ring[ch])
      );
   end

   // resynchronise the ring-domain overflow flags
   always_ff @(posedge clk) begin
      if (!nrst) begin
         ovf_meta <= '0;
         ovf      <= '0;
      end else begin
         ovf_meta <= ovf_ring;
         ovf      <= ovf_meta;
      end
   end

   // byte select; any out-of-range channel or byte leaves zero
   always_comb begin
      rd_next = 8'h00;
      for (int c = 0; c < NUM_RINGS; c++)
         for (int b = 0; b < NUM_BYTES; b++)
            if (int'(rd_ch) == c && int'(rd_byte) == b)
               rd_next = counts[c][b*8 +: 8];
   end

   // registered readout; counters are quiet once the FSM reaches DONE
   always_ff @(posedge clk) begin
      if (!nrst) rd_data <= 8'h00;
      else       rd_data <= rd_next;
   end

endmodule

// File: tb/tb_multi_ring_speed_test.sv
// tb/tb_multi_ring_speed_test.sv - directed scoreboard bench; expectations follow RING_OVF_EN
`timescale 1ns/1ps
module tb_multi_ring_speed_test;

   logic       clk = 1'b0;
   logic       nrst;
   logic       trig;
   logic [1:0] ring_en;
   logic [3:0] win_cycles;
   logic [0:0] rd_ch;
   logic [1:0] rd_byte;
   logic [7:0] rd_data;
   logic       busy, fired;
   logic [1:0] ovf;

   logic       trig8;
   logic [0:0] ring_en8;
   logic [3:0] win8;
   logic [0:0] rd_ch8;
   logic [0:0] rd_byte8;
   logic [7:0] rd_data8;
   logic       busy8, fired8;
   logic [0:0] ovf8;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       tag;
      bit          d8;
      int          ch;
      int unsigned lo;
      int unsigned hi;
   } exp_t;
   exp_t sb[$];
   int unsigned got [2];

   multi_ring_speed_test dut (
      .clk(clk), .nrst(nrst), .trig(trig), .ring_en(ring_en), .win_cycles(win_cycles),
      .rd_ch(rd_ch), .rd_byte(rd_byte), .rd_data(rd_data), .busy(busy), .fired(fired), .ovf(ovf)
   );

   multi_ring_speed_test #(.NUM_RINGS(1), .CNT_W(8)) dut8 (
      .clk(clk), .nrst(nrst), .trig(trig8), .ring_en(ring_en8), .win_cycles(win8),
      .rd_ch(rd_ch8), .rd_byte(rd_byte8), .rd_data(rd_data8), .busy(busy8), .fired(fired8), .ovf(ovf8)
   );

   always #50 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_range(input string tag, input int unsigned obs, input int unsigned lo, input int unsigned hi);
      checks++;
      assert ((obs >= lo && obs <= hi) === 1'b1) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h..%h", tag, obs, lo, hi);
      end
   endtask

   task automatic read_count(input bit d8, input int ch, output int unsigned val);
      val = 0;
      for (int b = 0; b < (d8 ? 1 : 3); b++) begin
         if (d8) begin rd_ch8 = 1'(ch); rd_byte8 = 1'(b); end
         else    begin rd_ch  = 1'(ch); rd_byte  = 2'(b); end
         @(negedge clk);
         val = val | (32'(d8 ? rd_data8 : rd_data) << (8 * b));
      end
   endtask

   task automatic expect_count(input string tag, input bit d8, input int ch, input int unsigned lo, input int unsigned hi);
      exp_t e;
      e.tag = tag; e.d8 = d8; e.ch = ch; e.lo = lo; e.hi = hi;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      int unsigned v;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         read_count(e.d8, e.ch, v);
         if (!e.d8) got[e.ch] = v;
         check_range(e.tag, v, e.lo, e.hi);
      end
   endtask

   task automatic measure(input bit d8, input logic [3:0] w, input int exp_busy, input int retrig_at, input string tag);
      int busy_n = 0;
      bit done   = 1'b0;
      if (d8) begin win8 = w; trig8 = 1'b1; end
      else    begin win_cycles = w; trig = 1'b1; end
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (i == 0 || i == retrig_at + 1) begin trig = 1'b0; trig8 = 1'b0; end
         if (i == retrig_at) trig = 1'b1;
         if (d8 ? busy8 : busy)   busy_n++;
         if (d8 ? fired8 : fired) done = 1'b1;
      end
      check({tag, "_fired"}, 32'(done), 32'd1);
      check({tag, "_busy_cycles"}, busy_n, exp_busy);
   endtask

   initial begin
      int bad;
      int diff;

      nrst = 1'b0; trig = 1'b0; ring_en = 2'b11; win_cycles = 4'd1; rd_ch = '0; rd_byte = '0;
      trig8 = 1'b0; ring_en8 = 1'b1; win8 = 4'd15; rd_ch8 = '0; rd_byte8 = '0;

      // 1: reset values, then idle with trig low
      repeat (3) @(negedge clk);
      check("rst_rd_data", rd_data, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_fired", fired, 1'b0);
      check("rst_ovf", ovf, 2'b00);
      nrst = 1'b1;
      bad = 0;
      repeat (5) begin @(negedge clk); if (busy !== 1'b0) bad++; end
      check("idle_busy", bad, 0);

      // 2: both rings, one-cycle window -> 25 edges each
      expect_count("t2_ch0", 1'b0, 0, 32'hFFFFE5, 32'hFFFFE7);
      expect_count("t2_ch1", 1'b0, 1, 32'hFFFFE5, 32'hFFFFE7);
      measure(1'b0, 4'd1, 6, -1, "t2");
      drain();
      diff = int'(got[0]) - int'(got[1]);
      if (diff < 0) diff = -diff;
      check_range("t2_ch_diff", diff, 0, 1);
      check("t2_ovf", ovf, 2'b00);
      rd_ch = 1'b0; rd_byte = 2'd3;
      @(negedge clk);
      check("t2_oor_byte", rd_data, 8'h00);

      // 3: channel 1 disabled, then a four-cycle window
      ring_en = 2'b01;
      expect_count("t3_ch0", 1'b0, 0, 32'hFFFFE5, 32'hFFFFE7);
      expect_count("t3_ch1", 1'b0, 1, 32'hFFFFFF, 32'hFFFFFF);
      measure(1'b0, 4'd1, 6, -1, "t3a");
      drain();
      expect_count("t3_ch0_w4", 1'b0, 0, 32'hFFFF9A, 32'hFFFF9C);
      measure(1'b0, 4'd4, 9, -1, "t3b");
      drain();

      // 4: a second trig edge during COUNT is dropped
      ring_en = 2'b11;
      expect_count("t4_ch0", 1'b0, 0, 32'hFFFFE5, 32'hFFFFE7);
      expect_count("t4_ch1", 1'b0, 1, 32'hFFFFE5, 32'hFFFFE7);
      measure(1'b0, 4'd1, 6, 2, "t4");
      bad = 0;
      repeat (5) begin @(negedge clk); if (busy !== 1'b0 || fired !== 1'b1) bad++; end
      check("t4_single_done", bad, 0);
      drain();

      // 5: reset pulse in the middle of COUNT, then a clean run
      win_cycles = 4'd4; trig = 1'b1;
      @(negedge clk); trig = 1'b0;
      @(negedge clk);
      @(negedge clk);
      nrst = 1'b0;
      @(negedge clk);
      check("t5_busy_after_rst", busy, 1'b0);
      check("t5_fired_after_rst", fired, 1'b0);
      nrst = 1'b1;
      @(negedge clk);
      expect_count("t5_ch0", 1'b0, 0, 32'hFFFF9A, 32'hFFFF9C);
      expect_count("t5_ch1", 1'b0, 1, 32'hFFFF9A, 32'hFFFF9C);
      measure(1'b0, 4'd4, 9, -1, "t5");
      drain();

      // 6: 8-bit counter, fifteen-cycle window -> 375 edges
`ifdef RING_OVF_EN
      expect_count("t6_cnt", 1'b1, 0, 32'h00, 32'h00);
`else
      expect_count("t6_cnt", 1'b1, 0, 32'h87, 32'h89);
`endif
      measure(1'b1, 4'd15, 20, -1, "t6");
      drain();
`ifdef RING_OVF_EN
      check("t6_ovf", ovf8, 1'b1);
`else
      check("t6_ovf", ovf8, 1'b0);
`endif
      rd_ch8 = 1'b0; rd_byte8 = 1'b1;
      @(negedge clk);
      check("t6_oor_byte", rd_data8, 8'h00);
      rd_ch8 = 1'b1; rd_byte8 = 1'b0;
      @(negedge clk);
      check("t6_oor_ch", rd_data8, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
